output_port_allocator: RTL and testbench
========================================

OUTPUT_PORT_ALLOCATOR -- requirements
Module: output_port_allocator

Interface
REQ-001 SHALL have parameter NUM_IN, default 5, meaning number of requesting input ports (index 4=north, 3=east, 2=west, 1=south, 0=local).
REQ-002 SHALL have parameter CREDIT_W, default 3, meaning width of the downstream credit count.
REQ-003 SHALL have parameter TIMEOUT, default 15, meaning stall cycles before watchdog release (used only with WATCHDOG_EN).
REQ-004 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port req_i, input, NUM_IN bits: input port holds a valid flit routed to this output.
REQ-007 SHALL have port head_i, input, NUM_IN bits: that flit is a header.
REQ-008 SHALL have port tail_i, input, NUM_IN bits: that flit is a tail; head and tail both set means a single-flit packet.
REQ-009 SHALL have port credit_i, input, CREDIT_W bits: free downstream slots.
REQ-010 SHALL have port grant_o, output, NUM_IN bits: one-hot owner of this output, registered.
REQ-011 SHALL have port send_o, output, NUM_IN bits: one-hot, owner's flit is forwarded this cycle (input buffer pop).
REQ-012 SHALL have port counter_minus_o, output, 1 bit: decrement downstream credit counter; equals |send_o.
REQ-013 SHALL have port busy_o, output, 1 bit: state is LOCKED.
REQ-014 SHALL have port timeout_o, output, 1 bit: watchdog release pulse.

Function
REQ-015 SHALL implement a two-state FSM: IDLE, LOCKED.
REQ-016 In IDLE, eligible = req_i & head_i when credit_i != 0; otherwise there are no eligible requesters.
REQ-017 In IDLE with any eligible requester, the FSM SHALL pick the first eligible index at or above rr_ptr (wrapping modulo NUM_IN), load grant_o one-hot, and enter LOCKED at the next edge.
REQ-018 Allocation latency SHALL be exactly one cycle; send_o SHALL be 0 in every IDLE cycle.
REQ-019 In LOCKED, send_o[i] = grant_o[i] & req_i[i] & (credit_i != 0), evaluated combinationally.
REQ-020 In LOCKED, grant_o SHALL NOT change while no tail is sent; body flits and requests from other ports SHALL be ignored.
REQ-021 A send with tail_i[owner]=1 SHALL return the FSM to IDLE at the next edge, clear grant_o, and set rr_ptr to (owner+1) mod NUM_IN.
REQ-022 A single-flit packet SHALL lock for exactly one send cycle and then release.
REQ-023 When credit_i==0 in LOCKED, the FSM SHALL hold state and grant and keep send_o=0.
REQ-024 rr_ptr SHALL update only on release, so a requester that is not granted cannot be starved for more than NUM_IN-1 packets.
REQ-025 A header from the owner port arriving while LOCKED SHALL be treated as a body flit (no re-arbitration).

Reset
REQ-026 Asserting rst at any time, including mid-packet, SHALL force state to IDLE, grant_o=0, rr_ptr=0, watchdog count=0 and timeout_o=0.
REQ-027 send_o and counter_minus_o SHALL be 0 while rst is high.

Configuration
REQ-028 Macro WATCHDOG_EN: when defined, a counter SHALL count consecutive LOCKED cycles with send_o=0 and clear on any send; on reaching TIMEOUT it SHALL force IDLE, advance rr_ptr past the owner, and pulse timeout_o high for one cycle.
REQ-029 Without WATCHDOG_EN, there SHALL be no counter, timeout_o SHALL be tied to 0, and LOCKED SHALL persist until a tail is sent.

Verification
REQ-030 After reset, drive req_i=5'b00001, head_i=5'b00001, credit_i=3 -> grant_o=5'b00001 one cycle later, then send_o=5'b00001 and counter_minus_o=1.
REQ-031 Drive three back-to-back packets with req_i=5'b10101 and heads on all three -> grants go 00001, 00100, 10000 in that order, and each is released on its tail.
REQ-032 While north (index 4) is locked, assert east head -> grant_o stays 5'b10000 until north's tail is sent, and east is granted in the cycle after release.
REQ-033 In LOCKED, hold credit_i=0 for 4 cycles -> send_o=0 with grant held; restore credit_i=2 -> send resumes.
REQ-034 Assert rst mid-packet -> grant_o=0 and busy_o=0 immediately; after rst is released, a new header is allocated starting from index 0.
REQ-035 With WATCHDOG_EN defined and TIMEOUT=15, lock west and hold req_i[2]=0 -> timeout_o pulses at the 15th stall cycle, then IDLE and rr_ptr=3.

Source files
------------

// File: rtl/output_port_allocator.sv
// output_port_allocator: round-robin wormhole allocator for one router output; define WATCHDOG_EN to add a stall watchdog.
module output_port_allocator #(
    parameter int NUM_IN   = 5,
    parameter int CREDIT_W = 3,
    parameter int TIMEOUT  = 15
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_IN-1:0]   req_i,
    input  logic [NUM_IN-1:0]   head_i,
    input  logic [NUM_IN-1:0]   tail_i,
    input  logic [CREDIT_W-1:0] credit_i,
    output logic [NUM_IN-1:0]   grant_o,
    output logic [NUM_IN-1:0]   send_o,
    output logic                counter_minus_o,
    output logic                busy_o,
    output logic                timeout_o
);
    typedef enum logic {IDLE, LOCKED} state_t;
    state_t state;
    // rr_ptr is kept one-hot so release is a rotate of the owner's grant
    logic [NUM_IN-1:0] rr_ptr;
    logic [NUM_IN-1:0] elig;
    logic [NUM_IN-1:0] upper;
    logic [NUM_IN-1:0] pick;
    logic credit_ok;
    logic tail_sent;
    logic wd_fire;

    assign credit_ok       = |credit_i;
    assign elig            = (state == IDLE && credit_ok) ? req_i & head_i : '0;
    assign upper           = elig & ~(rr_ptr - NUM_IN'(1));
    assign pick            = (|upper) ? upper & (~upper + NUM_IN'(1)) : elig & (~elig + NUM_IN'(1));
    assign send_o          = (state == LOCKED && !rst && credit_ok) ? grant_o & req_i : '0;
    assign counter_minus_o = |send_o;
    assign tail_sent       = |(send_o & tail_i);

`ifdef WATCHDOG_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);
    logic [WD_W-1:0] wd_cnt;
    assign wd_fire = state == LOCKED && !counter_minus_o && wd_cnt == WD_W'(TIMEOUT - 1);
`else
    assign wd_fire   = 1'b0;
    assign timeout_o = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            grant_o <= '0;
            busy_o  <= 1'b0;
            rr_ptr  <= NUM_IN'(1);
`ifdef WATCHDOG_EN
            wd_cnt    <= '0;
            timeout_o <= 1'b0;
`endif
        end else begin
`ifdef WATCHDOG_EN
            timeout_o <= wd_fire;
            wd_cnt    <= (state == LOCKED && !counter_minus_o && !wd_fire) ? wd_cnt + WD_W'(1) : '0;
`endif
            if (state == IDLE) begin
                if (|pick) begin
                    state   <= LOCKED;
                    grant_o <= pick;
                    busy_o  <= 1'b1;
                end
            end else if (tail_sent || wd_fire) begin
                state   <= IDLE;
                grant_o <= '0;
                busy_o  <= 1'b0;
                rr_ptr  <= {grant_o[NUM_IN-2:0], grant_o[NUM_IN-1]};
            end
        end
    end
endmodule

// File: tb/tb_output_port_allocator.sv
// tb_output_port_allocator: directed scoreboard bench for output_port_allocator (watchdog steps run only with WATCHDOG_EN).
module tb_output_port_allocator;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] req_i = '0;
    logic [4:0] head_i = '0;
    logic [4:0] tail_i = '0;
    logic [2:0] credit_i = '0;
    logic [4:0] grant_o;
    logic [4:0] send_o;
    logic       counter_minus_o;
    logic       busy_o;
    logic       timeout_o;

    typedef struct {
        string      tag;
        logic [4:0] grant;
        logic [4:0] send;
        logic       busy;
        logic       cm;
        logic       tmo;
    } exp_t;
    exp_t sb[$];
    int n_assert = 0;
    int n_fail = 0;

    output_port_allocator #(.NUM_IN(5), .CREDIT_W(3), .TIMEOUT(15)) dut (
        .clk(clk), .rst(rst), .req_i(req_i), .head_i(head_i), .tail_i(tail_i),
        .credit_i(credit_i), .grant_o(grant_o), .send_o(send_o),
        .counter_minus_o(counter_minus_o), .busy_o(busy_o), .timeout_o(timeout_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [4:0] obs, input logic [4:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check();
        exp_t e;
        e = sb.pop_front();
        chk({e.tag, ".grant"}, grant_o, e.grant);
        chk({e.tag, ".send"}, send_o, e.send);
        chk({e.tag, ".busy"}, {4'b0, busy_o}, {4'b0, e.busy});
        chk({e.tag, ".cm"}, {4'b0, counter_minus_o}, {4'b0, e.cm});
        chk({e.tag, ".timeout"}, {4'b0, timeout_o}, {4'b0, e.tmo});
    endtask

    // drive one cycle's inputs mid-low-phase, then compare outputs before the next rising edge
    task automatic cyc(input logic r, input logic [4:0] rq, input logic [4:0] hd, input logic [4:0] tl,
                       input logic [2:0] cr, input logic [4:0] eg, input logic [4:0] es, input logic et,
                       input string tag);
        exp_t e;
        @(negedge clk);
        rst = r;
        req_i = rq;
        head_i = hd;
        tail_i = tl;
        credit_i = cr;
        e.tag = tag;
        e.grant = eg;
        e.send = es;
        e.busy = |eg;
        e.cm = |es;
        e.tmo = et;
        sb.push_back(e);
        #1;
        check();
    endtask

    initial begin
        cyc(1, 5'b00000, 5'b00000, 5'b00000, 3'd0, 5'b00000, 5'b00000, 0, "reset");
        cyc(1, 5'b00001, 5'b00001, 5'b00001, 3'd3, 5'b00000, 5'b00000, 0, "reset_send_low");
        cyc(0, 5'b00001, 5'b00001, 5'b00000, 3'd3, 5'b00000, 5'b00000, 0, "alloc_idle");
        cyc(0, 5'b00001, 5'b00001, 5'b00001, 3'd3, 5'b00001, 5'b00001, 0, "single_flit");
        cyc(0, 5'b00000, 5'b00000, 5'b00000, 3'd3, 5'b00000, 5'b00000, 0, "released");
        cyc(1, 5'b00000, 5'b00000, 5'b00000, 3'd3, 5'b00000, 5'b00000, 0, "rst2");
        cyc(0, 5'b10101, 5'b10101, 5'b00000, 3'd3, 5'b00000, 5'b00000, 0, "rr_idle0");
        cyc(0, 5'b10101, 5'b10101, 5'b00001, 3'd3, 5'b00001, 5'b00001, 0, "rr_local");
        cyc(0, 5'b10101, 5'b10101, 5'b00000, 3'd3, 5'b00000, 5'b00000, 0, "rr_idle1");
        cyc(0, 5'b10101, 5'b10001, 5'b00000, 3'd3, 5'b00100, 5'b00100, 0, "rr_west_body");
        cyc(0, 5'b10101, 5'b10001, 5'b00100, 3'd3, 5'b00100, 5'b00100, 0, "rr_west_tail");
        cyc(0, 5'b10101, 5'b10001, 5'b00000, 3'd3, 5'b00000, 5'b00000, 0, "rr_idle2");
        cyc(0, 5'b10101, 5'b10001, 5'b10000, 3'd3, 5'b10000, 5'b10000, 0, "rr_north");
        cyc(0, 5'b10000, 5'b10000, 5'b00000, 3'd3, 5'b00000, 5'b00000, 0, "n_idle");
        cyc(0, 5'b11000, 5'b01000, 5'b00000, 3'd3, 5'b10000, 5'b10000, 0, "n_body_east_head");
        cyc(0, 5'b11000, 5'b11000, 5'b00000, 3'd3, 5'b10000, 5'b10000, 0, "n_owner_head");
        for (int i = 0; i < 4; i++)
            cyc(0, 5'b11000, 5'b01000, 5'b00000, 3'd0, 5'b10000, 5'b00000, 0, "credit0");
        cyc(0, 5'b11000, 5'b01000, 5'b00000, 3'd2, 5'b10000, 5'b10000, 0, "credit_back");
        cyc(0, 5'b11000, 5'b01000, 5'b10000, 3'd2, 5'b10000, 5'b10000, 0, "n_tail");
        cyc(0, 5'b01000, 5'b01000, 5'b00000, 3'd2, 5'b00000, 5'b00000, 0, "e_idle");
        cyc(0, 5'b01000, 5'b01000, 5'b01000, 3'd2, 5'b01000, 5'b01000, 0, "e_granted");
        cyc(0, 5'b10001, 5'b10001, 5'b00000, 3'd2, 5'b00000, 5'b00000, 0, "rr4_idle");
        cyc(0, 5'b10001, 5'b10001, 5'b00000, 3'd2, 5'b10000, 5'b10000, 0, "rr4_north");
        cyc(1, 5'b10001, 5'b10001, 5'b00000, 3'd2, 5'b00000, 5'b00000, 0, "mid_rst");
        cyc(0, 5'b10001, 5'b10001, 5'b00000, 3'd2, 5'b00000, 5'b00000, 0, "post_rst_idle");
        cyc(0, 5'b10001, 5'b10001, 5'b00000, 3'd2, 5'b00001, 5'b00001, 0, "post_rst_local");
        cyc(0, 5'b00001, 5'b00001, 5'b00001, 3'd2, 5'b00001, 5'b00001, 0, "local_tail");
        cyc(0, 5'b00100, 5'b00100, 5'b00000, 3'd0, 5'b00000, 5'b00000, 0, "idle_credit0");
        cyc(0, 5'b00100, 5'b00100, 5'b00000, 3'd0, 5'b00000, 5'b00000, 0, "still_idle");
        cyc(0, 5'b00100, 5'b00100, 5'b00000, 3'd1, 5'b00000, 5'b00000, 0, "idle_credit1");
        cyc(0, 5'b00100, 5'b00100, 5'b00100, 3'd1, 5'b00100, 5'b00100, 0, "west_single");
`ifdef WATCHDOG_EN
        cyc(1, 5'b00000, 5'b00000, 5'b00000, 3'd3, 5'b00000, 5'b00000, 0, "wd_rst");
        cyc(0, 5'b00100, 5'b00100, 5'b00000, 3'd3, 5'b00000, 5'b00000, 0, "wd_alloc");
        for (int i = 0; i < 15; i++)
            cyc(0, 5'b00000, 5'b00000, 5'b00000, 3'd3, 5'b00100, 5'b00000, 0, "wd_stall");
        cyc(0, 5'b00000, 5'b00000, 5'b00000, 3'd3, 5'b00000, 5'b00000, 1, "wd_fire");
        cyc(0, 5'b10101, 5'b10101, 5'b00000, 3'd3, 5'b00000, 5'b00000, 0, "wd_idle");
        cyc(0, 5'b10101, 5'b10101, 5'b00000, 3'd3, 5'b10000, 5'b10000, 0, "wd_rr3");
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
